// File: rtl/memoria_dados_janela_if.sv
// CPU data-bus view of the windowed data RAM: strobes, address/data and status returns.
interface memoria_dados_janela_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          write;
  logic          ler;
  logic          limpar;
  logic [AW-1:0] endereco;
  logic [DW-1:0] dado_in;
  logic [DW-1:0] dado_out;
  logic          dado_valido;
  logic          erro_endereco;
  logic          ocupado;

  modport master (
    output write, ler, limpar, endereco, dado_in,
    input  dado_out, dado_valido, erro_endereco, ocupado
  );

  modport slave (
    input  write, ler, limpar, endereco, dado_in,
    output dado_out, dado_valido, erro_endereco, ocupado
  );
endinterface

// File: rtl/memoria_dados_janela.sv
// Data RAM mapped at [BASE, BASE+DEPTH-1] with strobed access, pipelined read-valid,
// out-of-window error pulse and a hardware zero-fill sequencer that runs after reset or on request.
module memoria_dados_janela #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned BASE     = 128,
  parameter int unsigned DEPTH    = 96,
  parameter int unsigned LATENCIA = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  memoria_dados_janela_if.slave  bus
);

  localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] BASE_X    = (AW+1)'(BASE);
  localparam logic [AW:0] LAST_X    = (AW+1)'(BASE + DEPTH - 1);
  localparam logic [IW-1:0] LAST_IX = IW'(DEPTH - 1);

  localparam logic [0:0] LIMPA  = 1'b0;
  localparam logic [0:0] PRONTO = 1'b1;

  if (BASE + DEPTH > (2 ** AW)) begin : g_chk_map
    $error("memoria_dados_janela: BASE+DEPTH exceeds the address space");
  end
  if ((LATENCIA != 1) && (LATENCIA != 2)) begin : g_chk_lat
    $error("memoria_dados_janela: LATENCIA must be 1 or 2");
  end

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] fill_idx_q, fill_idx_d;
  logic          ocupado_q, ocupado_d;
  logic [DW-1:0] dado_out_q, dado_out_d;
  logic          valido_q, valido_d;
  logic          erro_q, erro_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we_c;
  logic [IW-1:0] mem_addr_c;
  logic [DW-1:0] mem_wdata_c;
  logic [DW-1:0] mem_rd_c;
  logic          rd_en_c;

  // Window decode in AW+1 bits so BASE+DEPTH never wraps back into range
  logic [AW:0]   addr_x_c;
  logic          in_win_c;
  logic [IW-1:0] idx_c;

  assign addr_x_c = {1'b0, bus.endereco};
  assign in_win_c = (addr_x_c >= BASE_X) && (addr_x_c <= LAST_X);
  assign idx_c    = IW'(addr_x_c - BASE_X);
  assign mem_rd_c = mem_q[idx_c];

  // Next state: fill sequencing in LIMPA, strobe service in PRONTO (limpar > write > ler)
  always_comb begin
    state_d     = state_q;
    fill_idx_d  = fill_idx_q;
    mem_we_c    = 1'b0;
    mem_addr_c  = fill_idx_q;
    mem_wdata_c = '0;
    rd_en_c     = 1'b0;
    erro_d      = 1'b0;
    case (state_q)
      LIMPA: begin
        mem_we_c = 1'b1;
        if (fill_idx_q == LAST_IX) begin
          state_d = PRONTO;
        end else begin
          fill_idx_d = fill_idx_q + 1'b1;
        end
      end
      default: begin
        if (bus.limpar) begin
          state_d    = LIMPA;
          fill_idx_d = '0;
        end else if (bus.write) begin
          if (in_win_c) begin
            mem_we_c    = 1'b1;
            mem_addr_c  = idx_c;
            mem_wdata_c = bus.dado_in;
          end else begin
            erro_d = 1'b1;
          end
        end else if (bus.ler) begin
          if (in_win_c) begin
            rd_en_c = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
        end
      end
    endcase
    ocupado_d = (state_d == LIMPA);
  end

  // Read return path; the optional second stage keeps draining through a fill request
  if (LATENCIA == 2) begin : g_lat2
    logic          s1_vld_q, s1_vld_d;
    logic [DW-1:0] s1_data_q, s1_data_d;

    always_comb begin
      s1_vld_d   = rd_en_c;
      s1_data_d  = rd_en_c ? mem_rd_c : s1_data_q;
      valido_d   = s1_vld_q;
      dado_out_d = s1_vld_q ? s1_data_q : dado_out_q;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_vld_q  <= 1'b0;
        s1_data_q <= '0;
      end else begin
        s1_vld_q  <= s1_vld_d;
        s1_data_q <= s1_data_d;
      end
    end
  end else begin : g_lat1
    always_comb begin
      valido_d   = rd_en_c;
      dado_out_d = rd_en_c ? mem_rd_c : dado_out_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LIMPA;
      fill_idx_q <= '0;
      ocupado_q  <= 1'b1;
      dado_out_q <= '0;
      valido_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      ocupado_q  <= ocupado_d;
      dado_out_q <= dado_out_d;
      valido_q   <= valido_d;
      erro_q     <= erro_d;
    end
  end

  // Storage is never reset; the fill sequencer clears it
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      mem_q[mem_addr_c] <= mem_wdata_c;
    end
  end

  assign bus.dado_out      = dado_out_q;
  assign bus.dado_valido   = valido_q;
  assign bus.erro_endereco = erro_q;
  assign bus.ocupado       = ocupado_q;

endmodule
